// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants used by the line conditioner and the
//               receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_OVERSAMPLE = 8;
    localparam int UART_BREAK_BITS = 10;
    localparam int UART_IDLE_BITS  = 10;
    localparam int GLITCH_CNT_W    = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
// ============================================================================
// Module      : uart_sync
// Description : Parameterised flop-chain synchroniser for asynchronous pins,
//               reset to 1 (UART idle level).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rx_line_cond.sv
// ============================================================================
// Module      : rx_line_cond
// Description : UART receive-pin conditioner: synchronise, deglitch, and flag
//               idle / break / start edges in the oversample clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_line_cond
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int BREAK_BITS  = UART_BREAK_BITS,
    parameter int IDLE_BITS   = UART_IDLE_BITS
) (
    input  logic                    rst,
    input  logic                    rx_clk,
    input  logic                    rx_pin,
    input  logic                    en,
    input  logic                    glitch_clr,
    output logic                    rx_line,
    output logic                    start_edge,
    output logic                    line_idle,
    output logic                    line_break,
    output logic                    brk_start,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

    localparam int RUN_MAX_I = max_int(BREAK_BITS * OVERSAMPLE, IDLE_BITS * OVERSAMPLE);
    localparam int RUN_W     = $clog2(RUN_MAX_I) + 1;
    localparam int DIFF_W    = $clog2(FILT_LEN);

    localparam logic [RUN_W-1:0]        C_RUN_MAX   = RUN_W'(RUN_MAX_I);
    localparam logic [RUN_W-1:0]        C_IDLE_CYC  = RUN_W'(IDLE_BITS * OVERSAMPLE);
    localparam logic [RUN_W-1:0]        C_BRK_CYC   = RUN_W'(BREAK_BITS * OVERSAMPLE);
    localparam logic [RUN_W-1:0]        C_BRK_CLR   = RUN_W'(OVERSAMPLE);
    localparam logic [DIFF_W-1:0]       C_DIFF_LAST = DIFF_W'(FILT_LEN - 1);
    localparam logic [GLITCH_CNT_W-1:0] C_GLT_MAX   = '1;

    logic                    w_s;
    logic                    w_glitch;

    logic                    rx_line_q,    rx_line_d;
    logic [DIFF_W-1:0]       diff_q,       diff_d;
    logic [RUN_W-1:0]        run_q,        run_d;
    logic                    idle_q,       idle_d;
    logic                    break_q,      break_d;
    logic                    start_q,      start_d;
    logic                    brk_start_q,  brk_start_d;
    logic [GLITCH_CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (rx_clk),
        .rst (rst),
        .d_i (rx_pin),
        .q_o (w_s)
    );

    always_comb begin
        rx_line_d   = rx_line_q;
        diff_d      = diff_q;
        run_d       = run_q;
        idle_d      = idle_q;
        break_d     = break_q;
        start_d     = 1'b0;
        brk_start_d = 1'b0;
        w_glitch    = 1'b0;

        if (!en) begin
            rx_line_d = 1'b1;
            diff_d    = '0;
            run_d     = '0;
            idle_d    = 1'b0;
            break_d   = 1'b0;
        end else begin
            if (w_s != rx_line_q) begin
                if (diff_q == C_DIFF_LAST) begin
                    rx_line_d = w_s;
                    diff_d    = '0;
                end else begin
                    diff_d = diff_q + 1'b1;
                end
            end else begin
                diff_d   = '0;
                w_glitch = (diff_q != '0);
            end

            if (rx_line_d != rx_line_q) begin
                run_d = RUN_W'(1);
            end else if (run_q != C_RUN_MAX) begin
                run_d = run_q + 1'b1;
            end

            // Flags track the level being committed this edge, so they
            // switch on the same edge as rx_line.
            if (rx_line_d) begin
                if (run_d >= C_IDLE_CYC) begin
                    idle_d = 1'b1;
                end
                if (break_q && (run_d >= C_BRK_CLR)) begin
                    break_d = 1'b0;
                end
            end else begin
                idle_d = 1'b0;
                if (!break_q && (run_d >= C_BRK_CYC)) begin
                    break_d     = 1'b1;
                    brk_start_d = 1'b1;
                end
            end

            start_d = rx_line_q & ~rx_line_d & ~break_q;
        end
    end

    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (glitch_clr) begin
            glitch_cnt_d = '0;
        end else if (w_glitch && (glitch_cnt_q != C_GLT_MAX)) begin
            glitch_cnt_d = glitch_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge rx_clk or negedge rst) begin
        if (!rst) begin
            rx_line_q    <= 1'b1;
            diff_q       <= '0;
            run_q        <= '0;
            idle_q       <= 1'b0;
            break_q      <= 1'b0;
            start_q      <= 1'b0;
            brk_start_q  <= 1'b0;
            glitch_cnt_q <= '0;
        end else begin
            rx_line_q    <= rx_line_d;
            diff_q       <= diff_d;
            run_q        <= run_d;
            idle_q       <= idle_d;
            break_q      <= break_d;
            start_q      <= start_d;
            brk_start_q  <= brk_start_d;
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign rx_line    = rx_line_q;
    assign start_edge = start_q;
    assign line_idle  = idle_q;
    assign line_break = break_q;
    assign brk_start  = brk_start_q;
    assign glitch_cnt = glitch_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_line_cond.sv
// ============================================================================
// Module      : tb_rx_line_cond
// Description : Directed self-checking bench for rx_line_cond.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_line_cond;

    logic       rst;
    logic       rx_clk;
    logic       rx_pin;
    logic       en;
    logic       glitch_clr;
    logic       rx_line;
    logic       start_edge;
    logic       line_idle;
    logic       line_break;
    logic       brk_start;
    logic [7:0] glitch_cnt;

    int n_pass;
    int n_total;

    rx_line_cond dut (
        .rst        (rst),
        .rx_clk     (rx_clk),
        .rx_pin     (rx_pin),
        .en         (en),
        .glitch_clr (glitch_clr),
        .rx_line    (rx_line),
        .start_edge (start_edge),
        .line_idle  (line_idle),
        .line_break (line_break),
        .brk_start  (brk_start),
        .glitch_cnt (glitch_cnt)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic glitch_pulse();
        rx_pin = 1'b0;
        step(2);
        rx_pin = 1'b1;
        step(4);
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst        = 1'b0;
        rx_pin     = 1'b1;
        en         = 1'b1;
        glitch_clr = 1'b0;

        // 1. reset and idle
        step(3);
        chk("rst_rx_line", rx_line, 1);
        chk("rst_start", start_edge, 0);
        chk("rst_idle", line_idle, 0);
        chk("rst_break", line_break, 0);
        chk("rst_brk_start", brk_start, 0);
        chk("rst_gcnt", glitch_cnt, 0);
        rst = 1'b1;
        step(60);
        chk("idle_early", line_idle, 0);
        step(22);
        chk("idle_set", line_idle, 1);

        // 2. start bit: rx_line falls 5 edges after pin falls
        rx_pin = 1'b0;
        step(4);
        chk("start_pre_line", rx_line, 1);
        chk("start_pre_idle", line_idle, 1);
        step(1);
        chk("start_line", rx_line, 0);
        chk("start_pulse", start_edge, 1);
        chk("start_idle_drop", line_idle, 0);
        step(1);
        chk("start_one_cycle", start_edge, 0);

        // 4. break: run count was 1 at the fall, now 2
        step(77);
        chk("brk_pre_79", line_break, 0);
        chk("brk_start_pre", brk_start, 0);
        step(1);
        chk("brk_set_80", line_break, 1);
        chk("brk_start_pulse", brk_start, 1);
        step(1);
        chk("brk_start_one", brk_start, 0);
        step(15);
        chk("brk_hold", line_break, 1);
        // short high excursion during the break, then low again
        rx_pin = 1'b1;
        step(3);
        rx_pin = 1'b0;
        step(2);
        chk("brk_exc_high", rx_line, 1);
        step(3);
        chk("brk_exc_low", rx_line, 0);
        chk("brk_no_start", start_edge, 0);
        chk("brk_still_set", line_break, 1);
        step(1);
        chk("brk_no_start2", start_edge, 0);
        // release: rx_line rises after 5, break clears on 8th high cycle
        rx_pin = 1'b1;
        step(5);
        chk("brk_rel_line", rx_line, 1);
        chk("brk_rel_hold", line_break, 1);
        step(6);
        chk("brk_clr_pre", line_break, 1);
        step(1);
        chk("brk_clr", line_break, 0);
        step(4);

        // 3. glitches
        glitch_pulse();
        chk("glt_line", rx_line, 1);
        chk("glt_cnt1", glitch_cnt, 1);
        for (int i = 0; i < 299; i++) begin
            glitch_pulse();
        end
        chk("glt_sat", glitch_cnt, 255);
        chk("glt_sat_line", rx_line, 1);
        rx_pin = 1'b0;
        step(2);
        rx_pin = 1'b1;
        step(2);
        glitch_clr = 1'b1;
        step(1);
        glitch_clr = 1'b0;
        chk("glt_clr_prio", glitch_cnt, 0);
        step(2);
        glitch_pulse();
        chk("glt_after_clr", glitch_cnt, 1);

        // 5. enable
        rx_pin = 1'b0;
        step(8);
        chk("en_line_low", rx_line, 0);
        en = 1'b0;
        step(1);
        chk("en_off_line", rx_line, 1);
        chk("en_off_start", start_edge, 0);
        chk("en_off_idle", line_idle, 0);
        chk("en_off_break", line_break, 0);
        chk("en_off_gcnt", glitch_cnt, 1);
        step(5);
        chk("en_off_hold", rx_line, 1);
        en = 1'b1;
        step(2);
        chk("en_on_qual", rx_line, 1);
        step(1);
        chk("en_on_line", rx_line, 0);
        chk("en_on_start", start_edge, 1);

        // 6. reset at low-run count 50
        step(49);
        chk("mid_pre_break", line_break, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_line", rx_line, 1);
        chk("mid_rst_start", start_edge, 0);
        chk("mid_rst_break", line_break, 0);
        step(2);
        rst = 1'b1;
        step(4);
        chk("mid_rel_line", rx_line, 1);
        chk("mid_rel_start", start_edge, 0);
        step(1);
        chk("mid_fall_line", rx_line, 0);
        chk("mid_fall_start", start_edge, 1);
        step(78);
        chk("mid_brk_pre", line_break, 0);
        step(1);
        chk("mid_brk_set", line_break, 1);
        chk("mid_brk_start", brk_start, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
